tone_arbiter: RTL and testbench
===============================

# tone_arbiter

Shares the single tone/LED output path (speaker frequency select, LED driver, `pressed` line) between three requesters: Simon playback, player button presses and the game-over alarm. It replaces the combinational priority mux in front of the frequency, LED and speaker blocks. The arbiter enforces a minimum tone length and a silent gap between tones, so short presses are audible and repeated same-colour tones stay distinct. When `game_over` is asserted it sequences an alarm pattern.

## Interface
Parameters:
- `CNT_W`, 8: width of the hold, gap and alarm counters.
- `MIN_HOLD`, 50: minimum tone length in `tick` pulses. Must be ≤ 2^CNT_W−1.
- `GAP`, 20: silent interval in `tick` pulses after each released tone.
- `ALARM_STEP`, 125: `tick` pulses per alarm step. Must be ≥ 1.

Ports:
- `clk` input 1: single system clock.
- `reset` input 1: asynchronous, active-low reset.
- `tick` input 1: one-`clk`-wide timebase strobe from the clock reducer.
- `simon_req` input 1: Simon is playing a colour.
- `simon_num` input 2: colour requested by Simon.
- `player_req` input 1: debounced player press.
- `player_num` input 2: colour pressed by the player.
- `game_over` input 1: level signal; high while the game is lost.
- `num` output 2: granted colour, to the frequency and LED blocks.
- `pressed` output 1: tone/LED enable.
- `owner` output 2: current owner. 0 = none, 1 = Simon, 2 = player, 3 = alarm.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, HOLD_SIMON, HOLD_PLAYER, GAP, ALARM. All outputs are registered.
- Priority: `game_over` > `simon_req` > `player_req`.
- IDLE:
  - If `game_over` is high, go to ALARM.
  - Else if `simon_req` is high, go to HOLD_SIMON.
  - Else if `player_req` is high, go to HOLD_PLAYER.
  - On a grant, `num` latches the requester's colour and `hold_cnt` clears.
- HOLD_x:
  - `num` stays frozen. Changes on `*_num` are ignored until release.
  - `hold_cnt` increments on `tick` and saturates at MIN_HOLD.
  - Release when `hold_cnt == MIN_HOLD` and `x_req` is low: go to GAP and clear `gap_cnt`.
  - If the request is still held, the tone continues indefinitely.
  - The other requester is ignored, not queued.
- GAP:
  - `pressed` = 0 and `num` holds its last value.
  - `gap_cnt` increments on `tick`. At `gap_cnt == GAP`, go to IDLE.
  - If GAP = 0, exit to IDLE on the next cycle.
- ALARM:
  - Entered from any state on the cycle after `game_over` is seen high (preemption).
  - `pressed` = 1 and `owner` = 3.
  - The alarm pattern is described under Configuration.
  - When `game_over` falls, go to GAP.
- MIN_HOLD = 0: release happens on the first cycle the request is seen low.
- `reset` low at any time, including mid-tone or mid-alarm:
  - Immediately forces IDLE and clears all counters.
  - Outputs go to `num`=0, `pressed`=0, `owner`=0, `busy`=0.

## Timing
- Grant latency is 1 clk: request seen high in IDLE at edge n gives `pressed` = 1 after edge n.
- Alarm preemption latency is 1 clk from any state.
- With `tick` tied high, a 1-cycle request gives `pressed` high for exactly MIN_HOLD+1 cycles.
- With `tick` tied high, GAP lasts GAP+1 cycles. The earliest next grant follows 1 cycle later.
- Counters advance only on cycles where `tick` = 1. `tick` does not affect grant or preemption latency.
- `owner` and `busy` change on the same edge as `pressed`.

## Configuration
- `TONE_ARB_ALARM_EN` defined:
  - On ALARM entry, `num` = 3 and `alarm_idx` = 3, `alarm_cnt` = 0.
  - Every ALARM_STEP ticks, `alarm_idx` decrements, wrapping 0→3, and `num` follows it.
- `TONE_ARB_ALARM_EN` undefined:
  - ALARM drives constant `num` = 0 and `pressed` = 1.
  - The alarm counter and index are not built.

## Structure
- A shared package `simon_pkg` holds:
  - `color_t` (2-bit colour typedef).
  - `arb_state_t` (the FSM enum).
  - Owner constants OWN_NONE, OWN_SIMON, OWN_PLAYER, OWN_ALARM.
- One natural sub-module, `tick_counter`: a CNT_W-bit counter with clear, enable on `tick`, saturation and a terminal compare.
  - Instantiated for the hold and gap counts, and for the alarm step count when enabled.

## Test plan
Bench parameters: MIN_HOLD=4, GAP=2, ALARM_STEP=3, `tick` tied high.
- 1-cycle `player_req`, `player_num`=2 → `pressed` high for 5 cycles with `num`=2, `owner`=2; then 3 silent cycles; then `busy`=0.
- `simon_req` and `player_req` rise on the same cycle, `simon_num`=1, `player_num`=3 → `owner`=1, `num`=1. The player request is dropped, with no grant after GAP if it has gone low.
- `simon_req` held 10 cycles and `simon_num` changed mid-tone → `num` stays at its latched value. `pressed` falls the cycle after the request drops.
- `game_over` rises during HOLD_PLAYER → next cycle `owner`=3. With the macro defined, `num` sequence is 3,3,3,3,2,2,2,1,…,0,3. `game_over` falling leads to GAP, then IDLE.
- `reset` asserted low mid-alarm → all outputs 0 immediately. After release, IDLE with no grant until a new request.
- Macro undefined, `game_over` high → constant `num`=0, `pressed`=1.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types for the Simon tone path: colour, arbiter FSM state, owner codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simon_pkg;

    typedef logic [1:0] color_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD_SIMON,
        ST_HOLD_PLAYER,
        ST_GAP,
        ST_ALARM
    } arb_state_t;

    localparam logic [1:0] OWN_NONE   = 2'd0;
    localparam logic [1:0] OWN_SIMON  = 2'd1;
    localparam logic [1:0] OWN_PLAYER = 2'd2;
    localparam logic [1:0] OWN_ALARM  = 2'd3;

endpackage

// File: rtl/tick_counter.sv
// Tick-enabled counter with sync clear and terminal flag (cnt == LIMIT); saturates or wraps to 1.
// Latency: done reflects the registered count.
// Backpressure: none; counts every cycle tick is high.
module tick_counter #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 1,
    parameter bit WRAP  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic done
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrapping restarts at 1 so the wrap tick itself counts toward the next period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q != LIM) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (WRAP) begin
                cnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LIM);

endmodule

// File: rtl/tone_arbiter.sv
// Arbitrates the tone/LED path between Simon, player and game-over alarm; alarm pattern when TONE_ARB_ALARM_EN.
// Latency: 1 clk from request (or game_over) to registered outputs.
// Backpressure: none; requests are levels, a losing requester is ignored, not queued.
module tone_arbiter
    import simon_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int MIN_HOLD   = 50,
    parameter int GAP        = 20,
    parameter int ALARM_STEP = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       simon_req,
    input  logic [1:0] simon_num,
    input  logic       player_req,
    input  logic [1:0] player_num,
    input  logic       game_over,
    output logic [1:0] num,
    output logic       pressed,
    output logic [1:0] owner,
    output logic       busy
);

    arb_state_t state_q, state_d;
    color_t     num_q, num_d;
    logic       pressed_q, pressed_d;
    logic [1:0] owner_q, owner_d;
    logic       busy_q, busy_d;

    logic hold_clr, hold_done;
    logic gap_clr, gap_done;

    assign hold_clr = !((state_q == ST_HOLD_SIMON) || (state_q == ST_HOLD_PLAYER));
    assign gap_clr  = (state_q != ST_GAP);

    tick_counter #(.CNT_W(CNT_W), .LIMIT(MIN_HOLD), .WRAP(1'b0)) u_hold_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (hold_clr),
        .tick  (tick),
        .done  (hold_done)
    );

    tick_counter #(.CNT_W(CNT_W), .LIMIT(GAP), .WRAP(1'b0)) u_gap_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (gap_clr),
        .tick  (tick),
        .done  (gap_done)
    );

`ifdef TONE_ARB_ALARM_EN
    color_t alarm_idx_q, alarm_idx_d;
    logic   alarm_clr, alarm_done, alarm_step;

    // Counter is zero on the entry cycle, so the first colour lasts one cycle longer.
    assign alarm_clr  = (state_q != ST_ALARM);
    assign alarm_step = alarm_done && tick;

    tick_counter #(.CNT_W(CNT_W), .LIMIT(ALARM_STEP), .WRAP(1'b1)) u_alarm_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (alarm_clr),
        .tick  (tick),
        .done  (alarm_done)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            pressed_q <= 1'b0;
            owner_q   <= OWN_NONE;
            busy_q    <= 1'b0;
`ifdef TONE_ARB_ALARM_EN
            alarm_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            pressed_q <= pressed_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
`ifdef TONE_ARB_ALARM_EN
            alarm_idx_q <= alarm_idx_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (game_over) begin
            state_d = ST_ALARM;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (simon_req) begin
                        state_d = ST_HOLD_SIMON;
                    end else if (player_req) begin
                        state_d = ST_HOLD_PLAYER;
                    end
                end
                ST_HOLD_SIMON:  if (hold_done && !simon_req)  state_d = ST_GAP;
                ST_HOLD_PLAYER: if (hold_done && !player_req) state_d = ST_GAP;
                ST_GAP:         if (gap_done)                 state_d = ST_IDLE;
                ST_ALARM:       state_d = ST_GAP;
                default:        state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the transition.
    always_comb begin
        num_d     = num_q;
        pressed_d = 1'b0;
        owner_d   = OWN_NONE;
        busy_d    = (state_d != ST_IDLE);
`ifdef TONE_ARB_ALARM_EN
        alarm_idx_d = alarm_idx_q;
`endif
        case (state_d)
            ST_HOLD_SIMON: begin
                pressed_d = 1'b1;
                owner_d   = OWN_SIMON;
                if (state_q == ST_IDLE) num_d = simon_num;
            end
            ST_HOLD_PLAYER: begin
                pressed_d = 1'b1;
                owner_d   = OWN_PLAYER;
                if (state_q == ST_IDLE) num_d = player_num;
            end
            ST_ALARM: begin
                pressed_d = 1'b1;
                owner_d   = OWN_ALARM;
`ifdef TONE_ARB_ALARM_EN
                if (state_q != ST_ALARM) begin
                    alarm_idx_d = 2'd3;
                end else if (alarm_step) begin
                    alarm_idx_d = alarm_idx_q - 2'd1;
                end
                num_d = alarm_idx_d;
`else
                num_d = '0;
`endif
            end
            default: begin
            end
        endcase
    end

    assign num     = num_q;
    assign pressed = pressed_q;
    assign owner   = owner_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter: MIN_HOLD=4, GAP=2, ALARM_STEP=3, tick tied high.
// Inputs change 1 time unit after posedge; outputs are sampled at the same point.
module tb_tone_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       simon_req;
    logic [1:0] simon_num;
    logic       player_req;
    logic [1:0] player_num;
    logic       game_over;
    logic [1:0] num;
    logic       pressed;
    logic [1:0] owner;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tone_arbiter #(
        .CNT_W      (8),
        .MIN_HOLD   (4),
        .GAP        (2),
        .ALARM_STEP (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .simon_req  (simon_req),
        .simon_num  (simon_num),
        .player_req (player_req),
        .player_num (player_num),
        .game_over  (game_over),
        .num        (num),
        .pressed    (pressed),
        .owner      (owner),
        .busy       (busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({pressed, busy, owner, num} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: got p=%b b=%b o=%0d n=%0d want all 0", pressed, busy, owner, num);
        end
        reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({pressed, busy, owner, num} !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got p=%b b=%b o=%0d n=%0d want all 0", pressed, busy, owner, num);
        end
    endtask

    task automatic test_player_single();
        player_num = 2'd2;
        player_req = 1'b1;
        cyc();
        player_req = 1'b0;
        player_num = 2'd0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({pressed, busy, owner, num} !== {1'b1, 1'b1, 2'd2, 2'd2}) begin
                errors++;
                $display("FAIL player_tone[%0d]: got p=%b b=%b o=%0d n=%0d want p=1 b=1 o=2 n=2",
                         i, pressed, busy, owner, num);
            end
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({pressed, busy, owner, num} !== {1'b0, 1'b1, 2'd0, 2'd2}) begin
                errors++;
                $display("FAIL player_gap[%0d]: got p=%b b=%b o=%0d n=%0d want p=0 b=1 o=0 n=2",
                         i, pressed, busy, owner, num);
            end
            cyc();
        end
        checks++;
        if ({pressed, busy, owner} !== 4'b0) begin
            errors++;
            $display("FAIL player_idle: got p=%b b=%b o=%0d want p=0 b=0 o=0", pressed, busy, owner);
        end
    endtask

    task automatic test_priority();
        simon_num  = 2'd1;
        player_num = 2'd3;
        simon_req  = 1'b1;
        player_req = 1'b1;
        cyc();
        simon_req  = 1'b0;
        player_req = 1'b0;
        checks++;
        if ({pressed, owner, num} !== {1'b1, 2'd1, 2'd1}) begin
            errors++;
            $display("FAIL priority_grant: got p=%b o=%0d n=%0d want p=1 o=1 n=1", pressed, owner, num);
        end
        for (int i = 0; i < 5; i++) cyc();
        checks++;
        if ({pressed, busy, owner} !== {1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL priority_gap: got p=%b b=%b o=%0d want p=0 b=1 o=0", pressed, busy, owner);
        end
        for (int i = 0; i < 5; i++) cyc();
        checks++;
        if ({pressed, busy, owner} !== 4'b0) begin
            errors++;
            $display("FAIL priority_no_player_grant: got p=%b b=%b o=%0d want p=0 b=0 o=0", pressed, busy, owner);
        end
    endtask

    task automatic test_hold_long();
        simon_num = 2'd2;
        simon_req = 1'b1;
        cyc();
        simon_num = 2'd0;
        checks++;
        if ({pressed, owner, num} !== {1'b1, 2'd1, 2'd2}) begin
            errors++;
            $display("FAIL hold_grant: got p=%b o=%0d n=%0d want p=1 o=1 n=2", pressed, owner, num);
        end
        for (int i = 1; i < 10; i++) begin
            if (i == 5) simon_num = 2'd3;
            cyc();
            checks++;
            if ({pressed, num} !== {1'b1, 2'd2}) begin
                errors++;
                $display("FAIL hold_frozen[%0d]: got p=%b n=%0d want p=1 n=2", i, pressed, num);
            end
        end
        simon_req = 1'b0;
        cyc();
        checks++;
        if ({pressed, busy, num} !== {1'b0, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL hold_release: got p=%b b=%b n=%0d want p=0 b=1 n=2", pressed, busy, num);
        end
        for (int i = 0; i < 3; i++) cyc();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_back_idle: got b=%b want b=0", busy);
        end
    endtask

    task automatic test_alarm();
        logic [1:0] exp_seq [16];
        logic [1:0] exp_last;
`ifdef TONE_ARB_ALARM_EN
        exp_seq  = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1,
                     2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3};
        exp_last = 2'd3;
`else
        for (int k = 0; k < 16; k++) exp_seq[k] = 2'd0;
        exp_last = 2'd0;
`endif
        player_num = 2'd1;
        player_req = 1'b1;
        cyc();
        player_req = 1'b0;
        checks++;
        if ({owner, num} !== {2'd2, 2'd1}) begin
            errors++;
            $display("FAIL alarm_pre_player: got o=%0d n=%0d want o=2 n=1", owner, num);
        end
        game_over = 1'b1;
        cyc();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({pressed, busy, owner, num} !== {1'b1, 1'b1, 2'd3, exp_seq[k]}) begin
                errors++;
                $display("FAIL alarm_seq[%0d]: got p=%b b=%b o=%0d n=%0d want p=1 b=1 o=3 n=%0d",
                         k, pressed, busy, owner, num, exp_seq[k]);
            end
            if (k < 15) cyc();
        end
        game_over = 1'b0;
        cyc();
        checks++;
        if ({pressed, busy, owner, num} !== {1'b0, 1'b1, 2'd0, exp_last}) begin
            errors++;
            $display("FAIL alarm_to_gap: got p=%b b=%b o=%0d n=%0d want p=0 b=1 o=0 n=%0d",
                     pressed, busy, owner, num, exp_last);
        end
        for (int i = 0; i < 3; i++) cyc();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL alarm_gap_idle: got b=%b want b=0", busy);
        end
    endtask

    task automatic test_reset_mid_alarm();
        game_over = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({pressed, owner} !== {1'b1, 2'd3}) begin
            errors++;
            $display("FAIL mid_alarm_active: got p=%b o=%0d want p=1 o=3", pressed, owner);
        end
        #1;
        reset     = 1'b0;
        game_over = 1'b0;
        #1;
        checks++;
        if ({pressed, busy, owner, num} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got p=%b b=%b o=%0d n=%0d want all 0", pressed, busy, owner, num);
        end
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        checks++;
        if ({pressed, busy, owner, num} !== 6'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got p=%b b=%b o=%0d n=%0d want all 0", pressed, busy, owner, num);
        end
        player_num = 2'd3;
        player_req = 1'b1;
        cyc();
        player_req = 1'b0;
        checks++;
        if ({pressed, owner, num} !== {1'b1, 2'd2, 2'd3}) begin
            errors++;
            $display("FAIL post_reset_grant: got p=%b o=%0d n=%0d want p=1 o=2 n=3", pressed, owner, num);
        end
        for (int i = 0; i < 9; i++) cyc();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_drain: got b=%b want b=0", busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        tick       = 1'b1;
        simon_req  = 1'b0;
        simon_num  = 2'd0;
        player_req = 1'b0;
        player_num = 2'd0;
        game_over  = 1'b0;
        test_reset();
        test_player_single();
        cyc();
        test_priority();
        test_hold_long();
        test_alarm();
        test_reset_mid_alarm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
